// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry FF, LSB first, one bit per clock.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' port for two's-complement subtraction (a - b).
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned   CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    always_comb begin
        fa_s       = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_c       = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        res_d      = {fa_s, res_q[WIDTH-1:1]};
        b_load     = b;
        carry_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load     = ~b;
            carry_load = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b_load;
                        carry_q <= carry_load;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry_q <= fa_c;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    res_q   <= res_d;
                    count_q <= count_q + CW'(1);
                    // The last shift publishes its own sum bit and carry directly.
                    if (count_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_c;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
